// File: rtl/pl_ifid_fetchq.sv
// pl_ifid_fetchq: IF/ID stage with an instruction fetch queue.
// Fetched words are buffered in a FQ_DEPTH circular queue. The head is decoded
// combinationally for operand-address lookup and registered into the ID stage on pop.
// Optional feature macro: IFID_PERF_CNT_EN adds saturating stall/flush counters.
//
// Queue occupancy (derived from count, no explicit state register):
//   state   | meaning
//   EMPTY   | count == 0, ID stage inserts bubbles
//   PARTIAL | 0 < count < FQ_DEPTH, push and pop both allowed
//   FULL    | count == FQ_DEPTH, fetch_ready low
module pl_ifid_fetchq #(
    parameter int PROG_CTR_WID = 10,
    parameter int NUM_DOMAINS  = 1,
    parameter int FQ_DEPTH     = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      fetch_valid,
    input  logic [15:0]               fetch_instr,
    input  logic [PROG_CTR_WID-1:0]   fetch_pc,
    output logic                      fetch_ready,
    input  logic                      flush,
    input  logic                      dec_stall,
    input  logic [NUM_DOMAINS*8-1:0]  op1_data,
    input  logic [NUM_DOMAINS*8-1:0]  op2_data,
    input  logic [7:0]                op3_data,
    output logic [3:0]                op1_addr,
    output logic [3:0]                op2_addr,
    output logic [2:0]                op3_addr,
    output logic                      load_true,
    output logic                      id_valid,
    output logic [36:0]               id_ctrl,
    output logic [PROG_CTR_WID-1:0]   id_pc,
    output logic [PROG_CTR_WID-1:0]   id_pred_pc,
    output logic [NUM_DOMAINS*8-1:0]  id_op1_dout,
    output logic [NUM_DOMAINS*8-1:0]  id_op2_dout,
    output logic [7:0]                id_op3_dout,
    output logic [3:0]                id_op1_addr,
    output logic [3:0]                id_op2_addr,
    output logic [2:0]                id_op3_addr,
    output logic [2:0]                id_res_addr
`ifdef IFID_PERF_CNT_EN
   ,output logic [15:0]               perf_stall_cnt,
    output logic [15:0]               perf_flush_cnt
`endif
);

    localparam int CW = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
    localparam logic [CW:0] FQ_FULL = FQ_DEPTH[CW:0];

    // id_ctrl bit positions
    localparam int B_ADD  = 36, B_OR   = 35, B_NOT  = 34, B_ANDB = 33, B_ORB  = 32;
    localparam int B_NOTB = 31, B_AND  = 30, B_CIN  = 29, B_CMPL = 28, B_JMP  = 27;
    localparam int B_CMP  = 26, B_SHL  = 25, B_LGCL = 24, B_ST   = 23, B_LD   = 22;
    localparam int B_WR   = 21, B_JGT  = 20, B_JLT  = 19, B_JEQ  = 18, B_JC   = 17;
    localparam int B_UJMP = 16, B_LDI  = 15, B_MUL  = 6,  B_RALU = 5,  B_UNRL = 4;
    localparam int B_RLLM = 3,  B_RDST = 2;

    localparam logic [4:0] OP_ADD  = 5'h01, OP_SUB   = 5'h02, OP_AND   = 5'h03, OP_OR    = 5'h04;
    localparam logic [4:0] OP_NOT  = 5'h05, OP_SHL   = 5'h06, OP_JMP   = 5'h07, OP_RLOAD = 5'h08;
    localparam logic [4:0] OP_RST  = 5'h09, OP_ANDB  = 5'h0A, OP_ORB   = 5'h0B, OP_NOTB  = 5'h0C;
    localparam logic [4:0] OP_CMP  = 5'h0D, OP_JGT   = 5'h0E, OP_JLT   = 5'h0F, OP_JEQ   = 5'h10;
    localparam logic [4:0] OP_JC   = 5'h11, OP_LDI   = 5'h12, OP_ADDMD = 5'h13, OP_SUBMD = 5'h14;
    localparam logic [4:0] OP_MULMD = 5'h15, OP_UNRL = 5'h17, OP_RLLM  = 5'h18;

    logic [15:0]             q_instr [FQ_DEPTH];
    logic [PROG_CTR_WID-1:0] q_pc    [FQ_DEPTH];
    logic [CW-1:0]           rd_ptr, wr_ptr;
    logic [CW:0]             count;
    logic                    q_empty, push, pop;
    logic [15:0]             head_instr;
    logic [PROG_CTR_WID-1:0] head_pc;
    logic [4:0]              head_op;
    logic [36:0]             dec;
    logic [PROG_CTR_WID+9:0] pred_ext;
    logic [PROG_CTR_WID-1:0] head_pred;

    assign q_empty     = (count == '0);
    assign fetch_ready = (count != FQ_FULL);
    assign push        = fetch_valid & fetch_ready & ~flush;
    assign pop         = ~q_empty & ~dec_stall & ~flush;

    assign head_instr = q_instr[rd_ptr];
    assign head_pc    = q_pc[rd_ptr];
    assign head_op    = head_instr[15:11];

    assign op1_addr  = q_empty ? 4'd0 : head_instr[3:0];
    assign op2_addr  = q_empty ? 4'd0 : head_instr[7:4];
    assign op3_addr  = (!q_empty && head_op == OP_RST) ? head_instr[10:8] : 3'd0;
    assign load_true = !q_empty && (head_op == OP_RLOAD);

    assign pred_ext  = {{PROG_CTR_WID{1'b0}}, head_instr[9:0]};
    assign head_pred = dec[B_JMP] ? pred_ext[PROG_CTR_WID-1:0] : '0;

    // Decode the queue head into the control bundle
    always_comb begin
        dec = '0;
        case (head_op)
            OP_ADD:   begin dec[B_ADD] = 1'b1; dec[B_WR] = 1'b1; end
            OP_SUB:   begin dec[B_ADD] = 1'b1; dec[B_CIN] = 1'b1; dec[B_CMPL] = 1'b1; dec[B_WR] = 1'b1; end
            OP_AND:   begin dec[B_AND] = 1'b1; dec[B_LGCL] = 1'b1; dec[B_WR] = 1'b1; end
            OP_OR:    begin dec[B_OR]  = 1'b1; dec[B_LGCL] = 1'b1; dec[B_WR] = 1'b1; end
            OP_NOT:   begin dec[B_NOT] = 1'b1; dec[B_LGCL] = 1'b1; dec[B_WR] = 1'b1; end
            OP_SHL:   begin dec[B_SHL] = 1'b1; dec[B_WR] = 1'b1; end
            OP_JMP:   begin dec[B_JMP] = 1'b1; dec[B_UJMP] = 1'b1; end
            OP_RLOAD: begin dec[B_LD]  = 1'b1; dec[B_WR] = 1'b1; end
            OP_RST:   dec[B_ST] = 1'b1;
            OP_ANDB:  begin dec[B_ANDB] = 1'b1; dec[B_WR] = 1'b1; end
            OP_ORB:   begin dec[B_ORB]  = 1'b1; dec[B_WR] = 1'b1; end
            OP_NOTB:  begin dec[B_NOTB] = 1'b1; dec[B_WR] = 1'b1; end
            OP_CMP:   dec[B_CMP] = 1'b1;
            OP_JGT:   begin dec[B_JMP] = 1'b1; dec[B_JGT] = 1'b1; end
            OP_JLT:   begin dec[B_JMP] = 1'b1; dec[B_JLT] = 1'b1; end
            OP_JEQ:   begin dec[B_JMP] = 1'b1; dec[B_JEQ] = 1'b1; end
            OP_JC:    begin dec[B_JMP] = 1'b1; dec[B_JC]  = 1'b1; end
            OP_LDI:   begin dec[B_LDI] = 1'b1; dec[B_WR] = 1'b1; end
            OP_ADDMD: begin dec[B_ADD] = 1'b1; dec[B_RALU] = 1'b1; dec[B_RDST] = 1'b1; dec[B_WR] = 1'b1; end
            OP_SUBMD: begin
                dec[B_ADD]  = 1'b1; dec[B_CMPL] = 1'b1; dec[B_RALU] = 1'b1;
                dec[B_RDST] = 1'b1; dec[B_WR]   = 1'b1;
            end
            OP_MULMD: begin dec[B_MUL] = 1'b1; dec[B_RALU] = 1'b1; dec[B_RDST] = 1'b1; dec[B_WR] = 1'b1; end
            OP_UNRL:  begin dec[B_UNRL] = 1'b1; dec[B_WR] = 1'b1; end
            OP_RLLM:  begin dec[B_RLLM] = 1'b1; dec[B_RDST] = 1'b1; dec[B_WR] = 1'b1; end
            default:  dec = '0;
        endcase
        // Immediate and register-file selects come straight from the word for every opcode
        dec[14:7] = head_instr[7:0];
        dec[1]    = head_instr[3];
        dec[0]    = head_instr[7];
    end

    // Queue storage; contents need no reset since count gates every read
    always_ff @(posedge clk) begin
        if (push) begin
            q_instr[wr_ptr] <= fetch_instr;
            q_pc[wr_ptr]    <= fetch_pc;
        end
    end

    // Queue pointers and occupancy; flush empties the queue and drops the concurrent fetch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // ID register: load on pop, bubble when empty, hold on stall, clear valid/ctrl on flush
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_valid    <= 1'b0;
            id_ctrl     <= '0;
            id_pc       <= '0;
            id_pred_pc  <= '0;
            id_op1_dout <= '0;
            id_op2_dout <= '0;
            id_op3_dout <= '0;
            id_op1_addr <= '0;
            id_op2_addr <= '0;
            id_op3_addr <= '0;
            id_res_addr <= '0;
        end else if (flush) begin
            id_valid <= 1'b0;
            id_ctrl  <= '0;
        end else if (pop) begin
            id_valid    <= 1'b1;
            id_ctrl     <= dec;
            id_pc       <= head_pc;
            id_pred_pc  <= head_pred;
            id_op1_dout <= op1_data;
            id_op2_dout <= op2_data;
            id_op3_dout <= op3_data;
            id_op1_addr <= head_instr[3:0];
            id_op2_addr <= head_instr[7:4];
            id_op3_addr <= (head_op == OP_RST) ? head_instr[10:8] : 3'd0;
            id_res_addr <= (head_op == OP_RST) ? 3'd0 : head_instr[10:8];
        end else if (!dec_stall) begin
            id_valid <= 1'b0;
            id_ctrl  <= '0;
        end
    end

`ifdef IFID_PERF_CNT_EN
    // Saturating counters for stalled-with-work cycles and flush cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (dec_stall && !q_empty && perf_stall_cnt != 16'hFFFF)
                perf_stall_cnt <= perf_stall_cnt + 16'd1;
            if (flush && perf_flush_cnt != 16'hFFFF)
                perf_flush_cnt <= perf_flush_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pl_ifid_fetchq.sv
// Directed bench for pl_ifid_fetchq (default parameters). Inputs change and
// outputs are sampled on the falling clock edge.
module tb_pl_ifid_fetchq;

    logic        clk = 1'b0;
    logic        rst, fetch_valid, flush, dec_stall;
    logic [15:0] fetch_instr;
    logic [9:0]  fetch_pc;
    logic [7:0]  op1_data, op2_data, op3_data;
    logic        fetch_ready, load_true, id_valid;
    logic [3:0]  op1_addr, op2_addr, id_op1_addr, id_op2_addr;
    logic [2:0]  op3_addr, id_op3_addr, id_res_addr;
    logic [36:0] id_ctrl;
    logic [9:0]  id_pc, id_pred_pc;
    logic [7:0]  id_op1_dout, id_op2_dout, id_op3_dout;
`ifdef IFID_PERF_CNT_EN
    logic [15:0] perf_stall_cnt, perf_flush_cnt;
`endif

    int checks = 0;
    int failures = 0;

    // Hand-computed control bundles (bit36=add ... bit21=wr_rf ... imm at [14:7])
    localparam logic [36:0] CTRL_ADD_0A31 = 37'h10_0020_1880;
    localparam logic [36:0] CTRL_LDI_957F = 37'h00_0020_BF82;
    localparam logic [36:0] CTRL_JMP_3955 = 37'h00_0801_2A80;
    localparam logic [36:0] CTRL_ST_4B21  = 37'h00_0080_1080;
    localparam logic [36:0] CTRL_LD_4213  = 37'h00_0060_0980;

    always #5 clk = ~clk;

    pl_ifid_fetchq dut (
        .clk(clk), .rst(rst),
        .fetch_valid(fetch_valid), .fetch_instr(fetch_instr), .fetch_pc(fetch_pc),
        .fetch_ready(fetch_ready), .flush(flush), .dec_stall(dec_stall),
        .op1_data(op1_data), .op2_data(op2_data), .op3_data(op3_data),
        .op1_addr(op1_addr), .op2_addr(op2_addr), .op3_addr(op3_addr),
        .load_true(load_true), .id_valid(id_valid), .id_ctrl(id_ctrl),
        .id_pc(id_pc), .id_pred_pc(id_pred_pc),
        .id_op1_dout(id_op1_dout), .id_op2_dout(id_op2_dout), .id_op3_dout(id_op3_dout),
        .id_op1_addr(id_op1_addr), .id_op2_addr(id_op2_addr),
        .id_op3_addr(id_op3_addr), .id_res_addr(id_res_addr)
`ifdef IFID_PERF_CNT_EN
       ,.perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    task automatic test_reset();
        rst = 1'b1; fetch_valid = 1'b0; fetch_instr = '0; fetch_pc = '0;
        flush = 1'b0; dec_stall = 1'b0; op1_data = '0; op2_data = '0; op3_data = '0;
        repeat (2) @(negedge clk);
        checks++; if (fetch_ready !== 1'b1) begin failures++; $display("FAIL reset_fetch_ready act=%0h exp=1", fetch_ready); end
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL reset_id_valid act=%0h exp=0", id_valid); end
        checks++; if (id_ctrl !== 37'h0) begin failures++; $display("FAIL reset_id_ctrl act=%0h exp=0", id_ctrl); end
        checks++; if (op1_addr !== 4'h0) begin failures++; $display("FAIL reset_op1_addr act=%0h exp=0", op1_addr); end
        checks++; if (id_pc !== 10'h0) begin failures++; $display("FAIL reset_id_pc act=%0h exp=0", id_pc); end
        rst = 1'b0;
    endtask

    task automatic test_add();
        fetch_valid = 1'b1; fetch_instr = 16'h0A31; fetch_pc = 10'd5;
        @(negedge clk);
        fetch_valid = 1'b0; op1_data = 8'h11; op2_data = 8'h22; op3_data = 8'h33;
        #1;
        checks++; if (op1_addr !== 4'd1) begin failures++; $display("FAIL add_head_op1 act=%0h exp=1", op1_addr); end
        checks++; if (op2_addr !== 4'd3) begin failures++; $display("FAIL add_head_op2 act=%0h exp=3", op2_addr); end
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL add_not_yet_valid act=%0h exp=0", id_valid); end
        @(negedge clk);
        checks++; if (id_valid !== 1'b1) begin failures++; $display("FAIL add_id_valid act=%0h exp=1", id_valid); end
        checks++; if (id_ctrl !== CTRL_ADD_0A31) begin failures++; $display("FAIL add_id_ctrl act=%0h exp=%0h", id_ctrl, CTRL_ADD_0A31); end
        checks++; if (id_res_addr !== 3'd2) begin failures++; $display("FAIL add_res_addr act=%0h exp=2", id_res_addr); end
        checks++; if (id_pc !== 10'd5) begin failures++; $display("FAIL add_id_pc act=%0h exp=5", id_pc); end
        checks++; if (id_op1_dout !== 8'h11 || id_op2_dout !== 8'h22) begin failures++; $display("FAIL add_op_dout act=%0h/%0h exp=11/22", id_op1_dout, id_op2_dout); end
        checks++; if (id_op1_addr !== 4'd1 || id_op2_addr !== 4'd3 || id_op3_addr !== 3'd0) begin failures++; $display("FAIL add_id_addrs act=%0h/%0h/%0h exp=1/3/0", id_op1_addr, id_op2_addr, id_op3_addr); end
        checks++; if (op1_addr !== 4'd0) begin failures++; $display("FAIL add_empty_op1 act=%0h exp=0", op1_addr); end
        @(negedge clk);
        checks++; if (id_valid !== 1'b0 || id_ctrl !== 37'h0) begin failures++; $display("FAIL add_bubble act=%0h/%0h exp=0/0", id_valid, id_ctrl); end
        checks++; if (id_pc !== 10'd5) begin failures++; $display("FAIL add_bubble_pc_hold act=%0h exp=5", id_pc); end
    endtask

    task automatic test_back_to_back();
        fetch_valid = 1'b1; fetch_instr = 16'h957F; fetch_pc = 10'd6;
        @(negedge clk);
        fetch_instr = 16'h3955; fetch_pc = 10'd7;
        @(negedge clk);
        fetch_valid = 1'b0;
        checks++; if (id_ctrl !== CTRL_LDI_957F) begin failures++; $display("FAIL ldi_id_ctrl act=%0h exp=%0h", id_ctrl, CTRL_LDI_957F); end
        checks++; if (id_res_addr !== 3'd5 || id_pc !== 10'd6) begin failures++; $display("FAIL ldi_res_pc act=%0h/%0h exp=5/6", id_res_addr, id_pc); end
        checks++; if (id_pred_pc !== 10'h0) begin failures++; $display("FAIL ldi_pred_pc act=%0h exp=0", id_pred_pc); end
        checks++; if (op1_addr !== 4'd5 || op2_addr !== 4'd5) begin failures++; $display("FAIL jmp_head_addrs act=%0h/%0h exp=5/5", op1_addr, op2_addr); end
        @(negedge clk);
        checks++; if (id_ctrl !== CTRL_JMP_3955) begin failures++; $display("FAIL jmp_id_ctrl act=%0h exp=%0h", id_ctrl, CTRL_JMP_3955); end
        checks++; if (id_pred_pc !== 10'h155) begin failures++; $display("FAIL jmp_pred_pc act=%0h exp=155", id_pred_pc); end
        checks++; if (id_valid !== 1'b1 || id_pc !== 10'd7) begin failures++; $display("FAIL jmp_valid_pc act=%0h/%0h exp=1/7", id_valid, id_pc); end
        @(negedge clk);
    endtask

    task automatic test_store_stall();
        logic [15:0] w [5];
        w[0] = 16'h4213; w[1] = 16'h0A31; w[2] = 16'h0B42; w[3] = 16'h0C53; w[4] = 16'h1111;
        fetch_valid = 1'b1; fetch_instr = 16'h4B21; fetch_pc = 10'd9; op3_data = 8'h5A;
        @(negedge clk);
        fetch_valid = 1'b0;
        #1;
        checks++; if (op3_addr !== 3'd3 || load_true !== 1'b0) begin failures++; $display("FAIL st_head act=%0h/%0h exp=3/0", op3_addr, load_true); end
        @(negedge clk);
        checks++; if (id_ctrl !== CTRL_ST_4B21) begin failures++; $display("FAIL st_id_ctrl act=%0h exp=%0h", id_ctrl, CTRL_ST_4B21); end
        checks++; if (id_op3_addr !== 3'd3 || id_res_addr !== 3'd0) begin failures++; $display("FAIL st_addrs act=%0h/%0h exp=3/0", id_op3_addr, id_res_addr); end
        checks++; if (id_op3_dout !== 8'h5A) begin failures++; $display("FAIL st_op3_dout act=%0h exp=5a", id_op3_dout); end
        dec_stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            fetch_valid = 1'b1; fetch_instr = w[i]; fetch_pc = 10'(20 + i); op3_data = 8'(i);
            @(negedge clk);
            if (i == 3) begin
                checks++; if (fetch_ready !== 1'b0) begin failures++; $display("FAIL stall_full_ready act=%0h exp=0", fetch_ready); end
            end
        end
        fetch_valid = 1'b0;
        #1;
        checks++; if (id_valid !== 1'b1 || id_ctrl !== CTRL_ST_4B21 || id_pc !== 10'd9) begin failures++; $display("FAIL stall_hold act=%0h/%0h/%0h exp=1/%0h/9", id_valid, id_ctrl, id_pc, CTRL_ST_4B21); end
        checks++; if (id_op3_dout !== 8'h5A) begin failures++; $display("FAIL stall_dout_hold act=%0h exp=5a", id_op3_dout); end
        checks++; if (load_true !== 1'b1 || op1_addr !== 4'd3 || op2_addr !== 4'd1) begin failures++; $display("FAIL stall_head act=%0h/%0h/%0h exp=1/3/1", load_true, op1_addr, op2_addr); end
        dec_stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (id_valid !== 1'b1 || id_pc !== 10'(20 + i)) begin failures++; $display("FAIL drain_%0d act=%0h/%0h exp=1/%0h", i, id_valid, id_pc, 20 + i); end
            if (i == 0) begin
                checks++; if (id_ctrl !== CTRL_LD_4213 || id_res_addr !== 3'd2) begin failures++; $display("FAIL drain_load act=%0h/%0h exp=%0h/2", id_ctrl, id_res_addr, CTRL_LD_4213); end
            end
        end
        checks++; if (id_res_addr !== 3'd4) begin failures++; $display("FAIL drain_last_rd act=%0h exp=4", id_res_addr); end
        @(negedge clk);
        checks++; if (id_valid !== 1'b0 || fetch_ready !== 1'b1) begin failures++; $display("FAIL drain_fifth_absent act=%0h/%0h exp=0/1", id_valid, fetch_ready); end
    endtask

    task automatic test_flush();
        fetch_valid = 1'b1; fetch_instr = 16'h0A31; fetch_pc = 10'd40;
        @(negedge clk);
        fetch_valid = 1'b0;
        @(negedge clk);
        dec_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            fetch_valid = 1'b1; fetch_instr = 16'h4213; fetch_pc = 10'(30 + i);
            @(negedge clk);
        end
        checks++; if (fetch_ready !== 1'b0 || id_valid !== 1'b1) begin failures++; $display("FAIL flush_pre act=%0h/%0h exp=0/1", fetch_ready, id_valid); end
        dec_stall = 1'b0; flush = 1'b1; fetch_instr = 16'h957F; fetch_pc = 10'd50;
        @(negedge clk);
        flush = 1'b0; fetch_valid = 1'b0;
        #1;
        checks++; if (fetch_ready !== 1'b1 || id_valid !== 1'b0 || id_ctrl !== 37'h0) begin failures++; $display("FAIL flush_full act=%0h/%0h/%0h exp=1/0/0", fetch_ready, id_valid, id_ctrl); end
        checks++; if (op1_addr !== 4'd0 || load_true !== 1'b0) begin failures++; $display("FAIL flush_empty_head act=%0h/%0h exp=0/0", op1_addr, load_true); end
        @(negedge clk);
        checks++; if (id_valid !== 1'b0 || id_pc !== 10'd40) begin failures++; $display("FAIL flush_no_replay act=%0h/%0h exp=0/28", id_valid, id_pc); end
        dec_stall = 1'b1; fetch_valid = 1'b1; fetch_instr = 16'h0A31; fetch_pc = 10'd61; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; fetch_valid = 1'b0;
        #1;
        checks++; if (op1_addr !== 4'd0 || fetch_ready !== 1'b1) begin failures++; $display("FAIL flush_drop_fetch act=%0h/%0h exp=0/1", op1_addr, fetch_ready); end
        dec_stall = 1'b0;
        @(negedge clk);
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL flush_drop_id act=%0h exp=0", id_valid); end
    endtask

    task automatic test_reset_midstream();
        fetch_valid = 1'b1; fetch_instr = 16'h0B42; fetch_pc = 10'd70;
        @(negedge clk);
        fetch_valid = 1'b0;
        @(negedge clk);
        dec_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            fetch_valid = 1'b1; fetch_instr = 16'h4213; fetch_pc = 10'(71 + i);
            @(negedge clk);
        end
        fetch_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checks++; if (id_valid !== 1'b0 || id_ctrl !== 37'h0 || id_pc !== 10'h0) begin failures++; $display("FAIL rst_mid_id act=%0h/%0h/%0h exp=0/0/0", id_valid, id_ctrl, id_pc); end
        checks++; if (id_res_addr !== 3'd0 || id_op1_addr !== 4'd0 || id_op2_addr !== 4'd0) begin failures++; $display("FAIL rst_mid_addrs act=%0h/%0h/%0h exp=0/0/0", id_res_addr, id_op1_addr, id_op2_addr); end
        checks++; if (op1_addr !== 4'd0 || load_true !== 1'b0 || fetch_ready !== 1'b1) begin failures++; $display("FAIL rst_mid_queue act=%0h/%0h/%0h exp=0/0/1", op1_addr, load_true, fetch_ready); end
        @(negedge clk);
        rst = 1'b0; dec_stall = 1'b0;
        @(negedge clk);
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_no_replay act=%0h exp=0", id_valid); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_back_to_back();
        test_store_stall();
        test_flush();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout act=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
